// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SRV_I = 2'd1,
    SRV_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-ported memory,
// with data priority bounded by a starvation counter that eventually lets a fetch through.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_starve_cnt;

  logic w_i_elig;
  logic w_d_elig;
  logic w_grant_d;
  logic w_grant_i;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  endfunction

  // A request whose completion pulse is showing is already served; masking it
  // here keeps a still-held request from being granted a second time.
  assign w_i_elig  = i_req & ~i_rvalid;
  assign w_d_elig  = d_req & ~d_rvalid;
  assign w_grant_d = w_d_elig & (~w_i_elig | (r_starve_cnt != CNT_MAX));
  assign w_grant_i = w_i_elig & ~w_grant_d;
  assign stall     = w_i_elig | w_d_elig;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_rvalid     <= 1'b0;
      d_rvalid     <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state      <= SRV_D;
            mem_req      <= 1'b1;
            mem_we       <= d_we;
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
            r_starve_cnt <= w_i_elig ? sat_inc(r_starve_cnt) : '0;
          end else if (w_grant_i) begin
            r_state      <= SRV_I;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= i_addr;
            mem_wdata    <= '0;
            r_starve_cnt <= '0;
          end
        end
        SRV_I: begin
          if (mem_ack) begin
            r_state  <= IDLE;
            mem_req  <= 1'b0;
            i_rvalid <= 1'b1;
            i_rdata  <= mem_rdata;
          end
        end
        SRV_D: begin
          if (mem_ack) begin
            r_state  <= IDLE;
            mem_req  <= 1'b0;
            d_rvalid <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, back-to-back, starvation, store,
// held-request and mid-transaction reset scenarios against hand-computed values.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .stall    (stall)
  );

  always #5 clock = ~clock;

  // Memory model: acks in the ack_delay-th cycle of a mem_req window;
  // read data is a fixed function of the address.
  int   mem_cyc   = 0;
  int   ack_delay = 1;
  logic ack_force = 1'b0;

  assign mem_ack   = ack_force | (mem_req & (mem_cyc >= ack_delay));
  assign mem_rdata = (mem_addr == 32'h10) ? 32'h0000_0013 : (mem_addr ^ 32'hC0DE_0000);

  int            n_checks = 0;
  int            n_errors = 0;
  logic [AW-1:0] grants[$];
  int            snaps[$];
  logic          prev_req = 1'b0;
  logic          i_gr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (mem_req) mem_cyc++;
    else mem_cyc = 0;
    if (mem_req && !prev_req) begin
      grants.push_back(mem_addr);
      snaps.push_back(int'(dut.r_starve_cnt));
    end
    prev_req = mem_req;
  endtask

  initial begin
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    tick();
    tick();
    check_eq("rst_mem_req",   64'(mem_req),   64'd0);
    check_eq("rst_mem_we",    64'(mem_we),    64'd0);
    check_eq("rst_mem_addr",  64'(mem_addr),  64'd0);
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check_eq("rst_i_rvalid",  64'(i_rvalid),  64'd0);
    check_eq("rst_d_rvalid",  64'(d_rvalid),  64'd0);
    check_eq("rst_i_rdata",   64'(i_rdata),   64'd0);
    check_eq("rst_d_rdata",   64'(d_rdata),   64'd0);
    check_eq("rst_stall",     64'(stall),     64'd0);
    reset = 1'b0;
    tick();

    // Fetch with a 3-cycle memory
    i_addr    = 32'h10;
    i_req     = 1'b1;
    ack_delay = 3;
    #1;
    check_eq("f_stall_pre", 64'(stall), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("f_mem_req",  64'(mem_req),  64'd1);
      check_eq("f_mem_addr", 64'(mem_addr), 64'h10);
      check_eq("f_mem_we",   64'(mem_we),   64'd0);
      check_eq("f_rvalid",   64'(i_rvalid), 64'd0);
    end
    tick();
    check_eq("f_rvalid_pulse", 64'(i_rvalid), 64'd1);
    check_eq("f_rdata",        64'(i_rdata),  64'h13);
    check_eq("f_mem_req_off",  64'(mem_req),  64'd0);
    i_req = 1'b0;
    tick();
    check_eq("f_rvalid_once", 64'(i_rvalid), 64'd0);

    // Request held one cycle past its completion
    ack_delay = 1;
    i_req     = 1'b1;
    tick();
    tick();
    check_eq("h_rvalid",     64'(i_rvalid), 64'd1);
    check_eq("h_stall_rv",   64'(stall),    64'd0);
    tick();
    check_eq("h_no_regrant", 64'(mem_req),  64'd0);
    check_eq("h_rvalid_off", 64'(i_rvalid), 64'd0);
    i_req = 1'b0;
    tick();
    check_eq("h_idle", 64'(mem_req), 64'd0);

    // Simultaneous requests: data first, fetch right behind
    d_addr = 32'h40;
    d_we   = 1'b0;
    d_req  = 1'b1;
    i_addr = 32'h10;
    i_req  = 1'b1;
    tick();
    check_eq("s_d_req",  64'(mem_req),  64'd1);
    check_eq("s_d_addr", 64'(mem_addr), 64'h40);
    check_eq("s_d_we",   64'(mem_we),   64'd0);
    tick();
    check_eq("s_d_rvalid", 64'(d_rvalid), 64'd1);
    check_eq("s_d_rdata",  64'(d_rdata),  64'hC0DE_0040);
    check_eq("s_gap",      64'(mem_req),  64'd0);
    check_eq("s_i_early",  64'(i_rvalid), 64'd0);
    d_req = 1'b0;
    tick();
    check_eq("s_i_req",      64'(mem_req),  64'd1);
    check_eq("s_i_addr",     64'(mem_addr), 64'h10);
    check_eq("s_d_rv_once",  64'(d_rvalid), 64'd0);
    tick();
    check_eq("s_i_rvalid", 64'(i_rvalid), 64'd1);
    check_eq("s_i_rdata",  64'(i_rdata),  64'h13);
    i_req = 1'b0;
    tick();
    check_eq("s_idle", 64'(mem_req), 64'd0);

    // Store: load data must not move
    d_we    = 1'b1;
    d_addr  = 32'h80;
    d_wdata = 32'hDEAD_BEEF;
    d_req   = 1'b1;
    ack_delay = 2;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("w_mem_req",   64'(mem_req),   64'd1);
      check_eq("w_mem_we",    64'(mem_we),    64'd1);
      check_eq("w_mem_addr",  64'(mem_addr),  64'h80);
      check_eq("w_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    end
    tick();
    check_eq("w_d_rvalid", 64'(d_rvalid), 64'd1);
    check_eq("w_d_rdata",  64'(d_rdata),  64'hC0DE_0040);
    check_eq("w_mem_off",  64'(mem_req),  64'd0);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    check_eq("w_rv_once", 64'(d_rvalid), 64'd0);

    // Starvation: the fetch side backs off only while a data completion shows
    grants.delete();
    snaps.delete();
    ack_delay = 1;
    d_addr = 32'h60;
    d_we   = 1'b0;
    d_req  = 1'b1;
    i_addr = 32'h20;
    i_req  = 1'b1;
    i_gr   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (grants.size() > 0 && grants[grants.size()-1] == 32'h20) i_gr = 1'b1;
      if (i_rvalid) break;
      if (!i_gr) i_req = ~d_rvalid;
    end
    check_eq("st_i_done", 64'(i_rvalid), 64'd1);
    check_eq("st_i_rdata", 64'(i_rdata), 64'hC0DE_0020);
    i_req = 1'b0;
    d_req = 1'b0;
    check_eq("st_ngrants", 64'(grants.size() >= 5), 64'd1);
    if (grants.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        check_eq($sformatf("st_grant%0d", k), 64'(grants[k]), (k == 4) ? 64'h20 : 64'h60);
        check_eq($sformatf("st_cnt%0d", k), 64'(snaps[k]), (k == 4) ? 64'd0 : 64'(k + 1));
      end
    end
    tick();
    tick();
    check_eq("st_idle", 64'(mem_req), 64'd0);

    // Reset in the middle of a data transaction, late ack afterwards
    ack_delay = 10;
    d_addr = 32'h44;
    d_we   = 1'b0;
    d_req  = 1'b1;
    tick();
    check_eq("r_mem_req_on", 64'(mem_req), 64'd1);
    reset = 1'b1;
    d_req = 1'b0;
    tick();
    check_eq("r_mem_req_rst", 64'(mem_req), 64'd0);
    check_eq("r_d_rdata_rst", 64'(d_rdata), 64'd0);
    reset     = 1'b0;
    ack_force = 1'b1;
    tick();
    check_eq("r_no_rvalid", 64'(d_rvalid), 64'd0);
    check_eq("r_mem_req",   64'(mem_req),  64'd0);
    check_eq("r_state",     64'(dut.r_state), 64'(IDLE));
    ack_force = 1'b0;
    tick();
    check_eq("r_no_rvalid2", 64'(d_rvalid), 64'd0);
    check_eq("r_no_irvalid", 64'(i_rvalid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
